// File: rtl/cnn_axi_regs.sv
// AXI4-Lite register block for the CNN accelerator control path.
// Holds CONTROL and IRQ registers, exposes read-only FSM status.
module cnn_axi_regs #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   control_reg,
  input  logic [DATA_WIDTH-1:0]   status_reg,
  input  logic [DATA_WIDTH-1:0]   frame_count_reg,
  input  logic [DATA_WIDTH-1:0]   error_code_reg,
  output logic                    irq
);

  localparam int IW = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    R_CTRL  = 3'd0,
    R_STAT  = 3'd1,
    R_FRAME = 3'd2,
    R_ERR   = 3'd3,
    R_IRQS  = 3'd4,
    R_IRQE  = 3'd5,
    R_NONE  = 3'd6
  } reg_e;

  function automatic reg_e decode(input logic [IW-1:0] idx);
    reg_e r;
    r = R_NONE;
    for (int i = 0; i < 6; i++)
      if (idx == IW'(i)) r = reg_e'(3'(i));
    return r;
  endfunction

  logic       ready_q;
  logic       aw_full;
  reg_e       aw_sel;
  logic       w_full;
  logic [1:0] w_bits;
  logic       w_strb0;
  logic       aw_hs;
  logic       w_hs;
  logic       ar_hs;
  logic       commit;

  logic                  ctrl_start;
  logic                  ctrl_pulse;
  logic [1:0]            irq_st;
  logic [1:0]            irq_en;
  logic [1:0]            irq_set;
  logic [1:0]            irq_clr;
  logic                  irq_q;
  logic [DATA_WIDTH-1:0] prev_frame;
  logic [DATA_WIDTH-1:0] prev_err;
  logic                  wr_ctrl;
  logic                  wr_irqs;
  logic                  wr_irqe;

  reg_e                  rd_sel;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [1:0]            rd_resp;

  // Address LSBs and upper data/strobe bits carry no state here.
  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         s_axi_wdata[DATA_WIDTH-1:2],
                         s_axi_wstrb[DATA_WIDTH/8-1:1]};

  assign s_axi_awready = ready_q & ~aw_full;
  assign s_axi_wready  = ready_q & ~w_full;
  assign s_axi_arready = ready_q & ~s_axi_rvalid;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign commit = aw_full & w_full & ~s_axi_bvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q      <= 1'b0;
      aw_full      <= 1'b0;
      aw_sel       <= R_CTRL;
      w_full       <= 1'b0;
      w_bits       <= 2'b00;
      w_strb0      <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else begin
      ready_q <= 1'b1;
      if (commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= (aw_sel == R_NONE) ? 2'b10 : 2'b00;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_sel  <= decode(s_axi_awaddr[ADDR_WIDTH-1:2]);
      end
      if (w_hs) begin
        w_full  <= 1'b1;
        w_bits  <= s_axi_wdata[1:0];
        w_strb0 <= s_axi_wstrb[0];
      end
    end
  end

  assign wr_ctrl = commit & w_strb0 & (aw_sel == R_CTRL);
  assign wr_irqs = commit & w_strb0 & (aw_sel == R_IRQS);
  assign wr_irqe = commit & w_strb0 & (aw_sel == R_IRQE);

  assign irq_set[0] = frame_count_reg != prev_frame;
  assign irq_set[1] = (prev_err == '0) & (error_code_reg != '0);
  assign irq_clr    = wr_irqs ? w_bits : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_start <= 1'b0;
      ctrl_pulse <= 1'b0;
      irq_st     <= 2'b00;
      irq_en     <= 2'b00;
      irq_q      <= 1'b0;
      prev_frame <= '0;
      prev_err   <= '0;
    end else begin
      if (wr_ctrl) ctrl_start <= w_bits[0];
      ctrl_pulse <= wr_ctrl & w_bits[1];
      if (wr_irqe) irq_en <= w_bits;
      // A set event in the clearing cycle keeps the bit high.
      irq_st     <= (irq_st & ~irq_clr) | irq_set;
      irq_q      <= |(irq_st & irq_en);
      prev_frame <= frame_count_reg;
      prev_err   <= error_code_reg;
    end
  end

  assign control_reg = {{(DATA_WIDTH-2){1'b0}}, ctrl_pulse, ctrl_start};
  assign irq         = irq_q;

  assign rd_sel = decode(s_axi_araddr[ADDR_WIDTH-1:2]);

  always_comb begin
    rd_val  = '0;
    rd_resp = 2'b00;
    case (rd_sel)
      R_CTRL:  rd_val = {{(DATA_WIDTH-1){1'b0}}, ctrl_start};
      R_STAT:  rd_val = status_reg;
      R_FRAME: rd_val = frame_count_reg;
      R_ERR:   rd_val = error_code_reg;
      R_IRQS:  rd_val = {{(DATA_WIDTH-2){1'b0}}, irq_st};
      R_IRQE:  rd_val = {{(DATA_WIDTH-2){1'b0}}, irq_en};
      default: rd_resp = 2'b10;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_val;
      s_axi_rresp  <= rd_resp;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_axi_regs.sv
// Bench for cnn_axi_regs: random AXI traffic against a cycle-level
// register model, plus directed cases with literal expectations.
module tb_cnn_axi_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [5:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] control_reg;
  logic [31:0] status_reg;
  logic [31:0] frame_count_reg;
  logic [31:0] error_code_reg;
  logic        irq;

  always #5 clk = ~clk;

  cnn_axi_regs dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .control_reg(control_reg), .status_reg(status_reg),
    .frame_count_reg(frame_count_reg), .error_code_reg(error_code_reg),
    .irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_rdy, m_bv, m_rv, m_start, m_pulse, m_irq;
  logic [1:0]  m_bresp, m_rresp, m_st, m_en;
  logic [31:0] m_rdata, m_pfc, m_pec;
  logic [5:0]  aw_q[$];
  logic [35:0] w_q[$];

  task automatic model_reset();
    m_rdy = 0; m_bv = 0; m_rv = 0; m_start = 0; m_pulse = 0; m_irq = 0;
    m_bresp = 0; m_rresp = 0; m_st = 0; m_en = 0;
    m_rdata = 0; m_pfc = 0; m_pec = 0;
    aw_q.delete(); w_q.delete();
  endtask

  function automatic logic [33:0] m_read(input logic [5:0] a);
    case (a[5:2])
      4'd0:    return {2'b00, 31'd0, m_start};
      4'd1:    return {2'b00, status_reg};
      4'd2:    return {2'b00, frame_count_reg};
      4'd3:    return {2'b00, error_code_reg};
      4'd4:    return {2'b00, 30'd0, m_st};
      4'd5:    return {2'b00, 30'd0, m_en};
      default: return {2'b10, 32'd0};
    endcase
  endfunction

  task automatic model_step();
    logic aw_hs, w_hs, ar_hs, commit, nxt_pulse, nxt_irq;
    logic [1:0] ev, clr, nxt_en;
    logic [5:0] a;
    logic [35:0] w;
    logic [33:0] rd;
    aw_hs  = s_axi_awvalid && m_rdy && aw_q.size() == 0;
    w_hs   = s_axi_wvalid && m_rdy && w_q.size() == 0;
    ar_hs  = s_axi_arvalid && m_rdy && !m_rv;
    commit = aw_q.size() > 0 && w_q.size() > 0 && !m_bv;
    ev     = {m_pec == 0 && error_code_reg != 0, frame_count_reg != m_pfc};
    clr = 0; nxt_pulse = 0; nxt_en = m_en;
    nxt_irq = |(m_st & m_en);
    if (ar_hs) begin
      rd = m_read(s_axi_araddr);
      m_rv = 1; m_rresp = rd[33:32]; m_rdata = rd[31:0];
    end else if (m_rv && s_axi_rready) begin
      m_rv = 0;
    end
    if (commit) begin
      a = aw_q.pop_front();
      w = w_q.pop_front();
      m_bv = 1;
      m_bresp = (a[5:2] > 4'd5) ? 2'b10 : 2'b00;
      if (w[32]) begin
        case (a[5:2])
          4'd0: begin m_start = w[0]; nxt_pulse = w[1]; end
          4'd4: clr = w[1:0];
          4'd5: nxt_en = w[1:0];
          default: ;
        endcase
      end
    end else if (m_bv && s_axi_bready) begin
      m_bv = 0;
    end
    if (aw_hs) aw_q.push_back(s_axi_awaddr);
    if (w_hs) w_q.push_back({s_axi_wstrb, s_axi_wdata});
    m_st = (m_st & ~clr) | ev;
    m_en = nxt_en;
    m_pulse = nxt_pulse;
    m_irq = nxt_irq;
    m_pfc = frame_count_reg;
    m_pec = error_code_reg;
    m_rdy = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      chk("awready", s_axi_awready, m_rdy && aw_q.size() == 0);
      chk("wready", s_axi_wready, m_rdy && w_q.size() == 0);
      chk("arready", s_axi_arready, m_rdy && !m_rv);
      chk("bvalid", s_axi_bvalid, m_bv);
      chk("bresp", s_axi_bresp, m_bresp);
      chk("rvalid", s_axi_rvalid, m_rv);
      chk("rdata", s_axi_rdata, m_rdata);
      chk("rresp", s_axi_rresp, m_rresp);
      chk("control", control_reg, {30'd0, m_pulse, m_start});
      chk("irq", irq, m_irq);
      if (!rst) model_step();
    end
  end

  int pulse_cnt = 0;
  always @(negedge clk) if (control_reg[1]) pulse_cnt <= pulse_cnt + 1;

  // ---------------- FSM-side input driver ----------------
  logic        rand_on = 0;
  logic [31:0] fc_dir = 0;
  logic [31:0] ec_dir = 0;

  initial begin
    frame_count_reg = 0;
    error_code_reg  = 0;
    status_reg      = 32'h0000_0013;
    forever begin
      @(posedge clk); #2;
      if (rand_on) begin
        if ($urandom_range(0, 3) == 0) frame_count_reg = frame_count_reg + 1;
        if ($urandom_range(0, 7) == 0)
          error_code_reg = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
        status_reg = $urandom;
      end else begin
        frame_count_reg = fc_dir;
        error_code_reg  = ec_dir;
      end
    end
  end

  // ---------------- AXI stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_aw(input logic [5:0] a, input int dly);
    logic hs;
    int n;
    cycles(dly);
    s_axi_awaddr = a; s_axi_awvalid = 1;
    hs = 0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = s_axi_awready;
      @(posedge clk); #1; n++;
    end
    s_axi_awvalid = 0;
    chk("aw_handshake", 32'(hs), 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                        input int dly);
    logic hs;
    int n;
    cycles(dly);
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1;
    hs = 0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = s_axi_wready;
      @(posedge clk); #1; n++;
    end
    s_axi_wvalid = 0;
    chk("w_handshake", 32'(hs), 1);
  endtask

  task automatic wait_b(input int dly, output logic [1:0] resp);
    logic seen;
    int n;
    cycles(dly);
    s_axi_bready = 1;
    seen = 0; n = 0; resp = 2'b11;
    while (!seen && n < 50) begin
      @(negedge clk); seen = s_axi_bvalid; resp = s_axi_bresp;
      @(posedge clk); #1; n++;
    end
    s_axi_bready = 0;
    chk("b_handshake", 32'(seen), 1);
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int adly,
                           input int wdly, input int bdly,
                           output logic [1:0] resp);
    fork
      send_aw(a, adly);
      send_w(d, s, wdly);
    join
    wait_b(bdly, resp);
  endtask

  task automatic axi_read(input logic [5:0] a, input int dly,
                          input int rdly, output logic [31:0] data,
                          output logic [1:0] resp);
    logic hs, seen;
    int n;
    cycles(dly);
    s_axi_araddr = a; s_axi_arvalid = 1;
    hs = 0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = s_axi_arready;
      @(posedge clk); #1; n++;
    end
    s_axi_arvalid = 0;
    chk("ar_handshake", 32'(hs), 1);
    cycles(rdly);
    s_axi_rready = 1;
    seen = 0; n = 0; data = 0; resp = 2'b11;
    while (!seen && n < 50) begin
      @(negedge clk); seen = s_axi_rvalid;
      data = s_axi_rdata; resp = s_axi_rresp;
      @(posedge clk); #1; n++;
    end
    s_axi_rready = 0;
    chk("r_handshake", 32'(seen), 1);
  endtask

  task automatic rand_write();
    logic [1:0] r;
    logic [5:0] a;
    a = 6'($urandom);
    axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2), r);
  endtask

  task automatic rand_read();
    logic [31:0] d;
    logic [1:0]  r;
    logic [5:0]  a;
    a = 6'($urandom);
    axi_read(a, $urandom_range(0, 3), $urandom_range(0, 2), d, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    logic        seen;
    int          p0;
    int          n;
    rst = 1;
    s_axi_awaddr = 0; s_axi_awvalid = 0;
    s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
    s_axi_bready = 0;
    s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    #1;
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_control", control_reg, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    cycles(2);

    // single-cycle AW+W commit to CONTROL
    axi_write(6'h00, 32'h1, 4'hF, 0, 0, 0, resp);
    chk("w_ctrl1_bresp", resp, 2'b00);
    chk("w_ctrl1_ctrl", control_reg, 32'h1);

    // START+RESET write: one pulse, readback shows bit0 only
    p0 = pulse_cnt;
    axi_write(6'h00, 32'h3, 4'hF, 0, 0, 0, resp);
    cycles(3);
    chk("pulse_count", pulse_cnt - p0, 1);
    chk("ctrl_after_pulse", control_reg, 32'h1);
    axi_read(6'h00, 0, 0, data, resp);
    chk("rd_ctrl_data", data, 32'h1);
    chk("rd_ctrl_resp", resp, 2'b00);

    // W leads AW by three cycles; strobe off leaves CONTROL intact
    axi_write(6'h00, 32'h0, 4'hE, 3, 0, 0, resp);
    chk("w_lead_bresp", resp, 2'b00);
    chk("w_lead_ctrl", control_reg, 32'h1);
    axi_write(6'h02, 32'h0, 4'h1, 3, 0, 1, resp);
    chk("w_lead2_ctrl", control_reg, 32'h0);

    // RO and unmapped accesses
    fc_dir = 32'h2A;
    cycles(2);
    axi_read(6'h08, 0, 0, data, resp);
    chk("rd_frame_data", data, 32'h2A);
    chk("rd_frame_resp", resp, 2'b00);
    axi_read(6'h20, 0, 1, data, resp);
    chk("rd_unmapped_data", data, 32'h0);
    chk("rd_unmapped_resp", resp, 2'b10);
    axi_write(6'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp);
    chk("w_unmapped_bresp", resp, 2'b10);
    axi_write(6'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp);
    chk("w_ro_bresp", resp, 2'b00);

    // frame interrupt: set, clear, and set-wins-over-clear
    fc_dir = 0;
    cycles(2);
    axi_write(6'h10, 32'h3, 4'h1, 0, 0, 0, resp);
    axi_write(6'h14, 32'h1, 4'h1, 0, 0, 0, resp);
    cycles(2);
    chk("irq_idle", irq, 0);
    fc_dir = 1;
    cycles(3);
    chk("irq_frame", irq, 1);
    axi_write(6'h10, 32'h1, 4'h1, 0, 0, 0, resp);
    cycles(2);
    chk("irq_cleared", irq, 0);
    fc_dir = 2;
    cycles(3);
    chk("irq_again", irq, 1);
    fork
      send_aw(6'h10, 0);
      send_w(32'h1, 4'h1, 0);
    join
    fc_dir = 3;
    wait_b(0, resp);
    cycles(2);
    chk("irq_set_wins", irq, 1);
    axi_read(6'h10, 0, 0, data, resp);
    chk("rd_irqs_set_wins", data, 32'h1);

    // error interrupt on zero -> nonzero
    axi_write(6'h14, 32'h2, 4'h1, 0, 0, 0, resp);
    ec_dir = 32'h5;
    cycles(3);
    chk("irq_err", irq, 1);
    axi_read(6'h10, 0, 0, data, resp);
    chk("rd_irqs_err", data, 32'h3);

    // concurrent random traffic with a moving FSM side
    rand_on = 1;
    for (int i = 0; i < 60; i++) begin
      fork
        rand_write();
        rand_read();
      join
    end
    rand_on = 0;
    fc_dir = frame_count_reg;
    ec_dir = 0;
    cycles(3);

    // asynchronous reset with a pending write response
    axi_write(6'h00, 32'h0, 4'hF, 0, 0, 0, resp);
    fork
      send_aw(6'h00, 0);
      send_w(32'h1, 4'hF, 0);
    join
    seen = 0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk); seen = s_axi_bvalid;
      @(posedge clk); #1; n++;
    end
    chk("bvalid_pending", 32'(seen), 1);
    chk("ctrl_pending", control_reg, 32'h1);
    #2 rst = 1;
    #1;
    chk("async_bvalid", s_axi_bvalid, 0);
    chk("async_control", control_reg, 32'h0);
    chk("async_irq", irq, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    cycles(2);
    axi_write(6'h14, 32'h2, 4'h1, 0, 0, 0, resp);
    axi_read(6'h14, 0, 0, data, resp);
    chk("post_rst_irqe", data, 32'h2);
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
